// File: rtl/mips_mem_responder_if.sv
// mips_mem_responder_if: CPU-side memory bus between a MIPS core and its memory responder
interface mips_mem_responder_if;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        err;
   modport master (output address, read, write, writedata, byteenable,
                   input waitrequest, readdata, err);
   modport slave (input address, read, write, writedata, byteenable,
                  output waitrequest, readdata, err);
endinterface

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: wait-stated word memory answering one CPU access at a time
module mips_mem_responder #(
  parameter int          MEM_WORDS   = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter string       INIT_FILE   = ""
) (
  input logic clk,
  input logic reset_n,
  mips_mem_responder_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic          bad_q, rd_q, wr_q, err_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem [MEM_WORDS];
  logic [31:0]   off_now;
  logic          bad_now, req;
  logic [AW-1:0] idx_src;
  logic [31:0]   word_src;
  assign req = bus.read | bus.write;
  assign off_now = bus.address - BASE_ADDR;
  assign bad_now = (off_now >= 32'(MEM_WORDS * 4)) || (bus.address[1:0] != 2'b00);
  assign idx_src = (state == IDLE) ? off_now[AW+1:2] : idx_q;
  assign word_src = ((state == IDLE) ? bad_now : bad_q) ? 32'h0 : mem[idx_src];
  assign bus.waitrequest = (state != DONE) & req;
  assign bus.readdata = rdata_q;
  assign bus.err = err_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      bad_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else
      case (state)
        IDLE: if (req) begin
          cnt   <= 4'(WAIT_CYCLES - 1);
          idx_q <= off_now[AW+1:2];
          bad_q <= bad_now;
          rd_q  <= bus.read & ~bus.write;
          wr_q  <= bus.write & ~bus.read;
          if (bad_now | (bus.read & bus.write)) err_q <= 1'b1;
          if (WAIT_CYCLES > 1) state <= BUSY;
          else begin
            state <= DONE;
            if (bus.read & ~bus.write) rdata_q <= word_src;
          end
        end
        BUSY: if (!req) begin
          state <= IDLE;
          err_q <= 1'b1;
        end else begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= DONE;
            if (rd_q) rdata_q <= word_src;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
  always_ff @(posedge clk)
    if (reset_n && state == DONE && wr_q && !bad_q)
      for (int b = 0; b < 4; b++)
        if (bus.byteenable[b]) mem[idx_q][8*b +: 8] <= bus.writedata[8*b +: 8];
endmodule
